// File: rtl/loop_player.sv
// ---------------------------------------------------------------------------
// loop_player
//
// Plays back a recorded multi-bank step loop. On every beat_tick it reads
// the current step from each bank of the recorder's memory (one bank per
// clock), ORs together the banks whose play switch is on, and presents the
// result on looper_vector with a one-cycle output_ready strobe. The step
// index then advances, wrapping at loop_length (0 means 2^STEP_BITS).
//
// Ports
//   clock_loop     system clock, rising edge
//   reset_n        asynchronous active-low reset
//   beat_tick      one-cycle request for the next step
//   loop_switches  per-bank play enable (bit k -> bank k)
//   loop_length    loop length in steps, 0 = 2^STEP_BITS
//   mem_addr       {bank[2:0], step} read address to bank memory
//   mem_data       read data, valid one clock after mem_addr
//   looper_vector  registered OR of enabled banks at output_step
//   output_ready   one-cycle pulse when looper_vector updates
//   output_step    step index that produced looper_vector
//   overrun        (only with LOOP_PLAYER_OVERRUN_FLAG_EN) sticky flag,
//                  set when a tick is dropped, cleared only by reset
//
// Build option: define LOOP_PLAYER_OVERRUN_FLAG_EN to add the overrun port.
// BANKS must not exceed 8 (the bank field of mem_addr is 3 bits).
// ---------------------------------------------------------------------------
module loop_player #(
    parameter int VECTOR_WIDTH = 16,
    parameter int STEP_BITS    = 8,
    parameter int BANKS        = 7
) (
    input  logic                      clock_loop,
    input  logic                      reset_n,
    input  logic                      beat_tick,
    input  logic [BANKS-1:0]          loop_switches,
    input  logic [STEP_BITS-1:0]      loop_length,
    output logic [3+STEP_BITS-1:0]    mem_addr,
    input  logic [VECTOR_WIDTH-1:0]   mem_data,
    output logic [VECTOR_WIDTH-1:0]   looper_vector,
    output logic                      output_ready,
    output logic [STEP_BITS-1:0]      output_step
`ifdef LOOP_PLAYER_OVERRUN_FLAG_EN
    ,
    output logic                      overrun
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [2:0] LAST_BANK = 3'(BANKS - 1);

    state_t                  state_q, state_d;
    logic [STEP_BITS-1:0]    step_q, step_d;
    logic [2:0]              bank_q, bank_d;
    logic                    pending_q, pending_d;
    logic [BANKS-1:0]        switches_q, switches_d;
    logic [STEP_BITS-1:0]    length_q, length_d;
    logic [VECTOR_WIDTH-1:0] acc_q, acc_d;
    logic [VECTOR_WIDTH-1:0] vector_q, vector_d;
    logic [STEP_BITS-1:0]    out_step_q, out_step_d;
    logic                    ready_q, ready_d;
`ifdef LOOP_PLAYER_OVERRUN_FLAG_EN
    logic                    overrun_q, overrun_d;
`endif

    // Switch snapshot padded to 8 bits so it can be indexed by any 3-bit bank.
    logic [7:0]              sw_pad;
    logic [STEP_BITS:0]      step_inc;
    logic [STEP_BITS:0]      len_eff;
    logic                    step_wrap;

    assign sw_pad   = 8'(switches_q);
    assign step_inc = (STEP_BITS+1)'(step_q) + 1'b1;
    assign len_eff  = (length_q == '0) ? ((STEP_BITS+1)'(1) << STEP_BITS)
                                       : (STEP_BITS+1)'(length_q);
    // ">=" rather than "==" so a length shrunk below the current step
    // still wraps to 0 at the next advance.
    assign step_wrap = (step_inc >= len_eff);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        bank_d     = bank_q;
        pending_d  = pending_q;
        switches_d = switches_q;
        length_d   = length_q;
        acc_d      = acc_q;
        vector_d   = vector_q;
        out_step_d = out_step_q;
        ready_d    = 1'b0;
`ifdef LOOP_PLAYER_OVERRUN_FLAG_EN
        overrun_d  = overrun_q | (beat_tick && (state_q != IDLE) && pending_q);
`endif

        // One-deep tick buffer while busy; a second tick is simply dropped.
        if (beat_tick && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (beat_tick || pending_q) begin
                    state_d    = SCAN;
                    bank_d     = 3'd0;
                    acc_d      = '0;
                    pending_d  = 1'b0;
                    switches_d = loop_switches;
                    length_d   = loop_length;
                end
            end
            SCAN: begin
                // mem_data now holds the bank addressed on the previous clock.
                if ((bank_q != 3'd0) && sw_pad[bank_q - 3'd1]) begin
                    acc_d = acc_q | mem_data;
                end
                if (bank_q == LAST_BANK) begin
                    state_d = DRAIN;
                end else begin
                    bank_d = bank_q + 3'd1;
                end
            end
            DRAIN: begin
                // Last bank's data arrives here; include it in the output.
                if (sw_pad[LAST_BANK]) begin
                    acc_d = acc_q | mem_data;
                end
                vector_d   = acc_d;
                out_step_d = step_q;
                ready_d    = 1'b1;
                bank_d     = 3'd0;
                state_d    = DONE;
            end
            DONE: begin
                step_d  = step_wrap ? '0 : step_inc[STEP_BITS-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_loop or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            bank_q     <= 3'd0;
            pending_q  <= 1'b0;
            switches_q <= '0;
            length_q   <= '0;
            acc_q      <= '0;
            vector_q   <= '0;
            out_step_q <= '0;
            ready_q    <= 1'b0;
`ifdef LOOP_PLAYER_OVERRUN_FLAG_EN
            overrun_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            bank_q     <= bank_d;
            pending_q  <= pending_d;
            switches_q <= switches_d;
            length_q   <= length_d;
            acc_q      <= acc_d;
            vector_q   <= vector_d;
            out_step_q <= out_step_d;
            ready_q    <= ready_d;
`ifdef LOOP_PLAYER_OVERRUN_FLAG_EN
            overrun_q  <= overrun_d;
`endif
        end
    end

    assign mem_addr      = (state_q == SCAN) ? {bank_q, step_q} : '0;
    assign looper_vector = vector_q;
    assign output_ready  = ready_q;
    assign output_step   = out_step_q;
`ifdef LOOP_PLAYER_OVERRUN_FLAG_EN
    assign overrun       = overrun_q;
`endif

endmodule

// File: doc/loop_player.md
LOOP_PLAYER -- requirements
Module: loop_player

Interface
REQ-001 SHALL have parameter VECTOR_WIDTH, default 16, the width of one step vector (keypad/looper width).
REQ-002 SHALL have parameter STEP_BITS, default 8, the width of the step index (max 256 steps per loop).
REQ-003 SHALL have parameter BANKS, default 7, the number of recorded banks, one per loop_switches bit.
REQ-004 clock_loop  input  1  the single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 beat_tick  input  1  one-cycle pulse, synchronous to clock_loop, requesting the next step.
REQ-007 loop_switches  input  BANKS  per-bank play enable; bit k enables bank k.
REQ-008 loop_length  input  STEP_BITS  loop length in steps; 0 means 2^STEP_BITS.
REQ-009 mem_addr  output  3+STEP_BITS  read address {bank[2:0], step}, driven to the recorder's bank memory.
REQ-010 mem_data  input  VECTOR_WIDTH  read data, valid exactly one clock after mem_addr.
REQ-011 looper_vector  output  VECTOR_WIDTH  registered OR of all enabled banks at the current step.
REQ-012 output_ready  output  1  one-cycle pulse; looper_vector updated this cycle.
REQ-013 output_step  output  STEP_BITS  step index that produced the current looper_vector.

Function
REQ-014 SHALL implement the FSM states IDLE, SCAN, DRAIN and DONE.
REQ-015 IDLE: on a beat_tick or a pending tick, SHALL go to SCAN with bank=0, and SHALL snapshot loop_switches and loop_length into registers.
REQ-016 SCAN: SHALL drive mem_addr={bank,step}, increment bank each clock for BANKS clocks (0..BANKS-1), then go to DRAIN.
REQ-017 Each clock in SCAN (except the first) and in DRAIN SHALL OR mem_data into the accumulator only if the snapshot bit of the bank addressed on the previous clock is 1.
REQ-018 On entering SCAN, the accumulator SHALL be cleared to 0.
REQ-019 DRAIN -> DONE: SHALL register looper_vector=accumulator and output_step=step, and assert output_ready for the DONE cycle only.
REQ-020 DONE: step SHALL be set to step+1, or to 0 when step+1 equals the snapshot length (256 when the snapshot is 0); the FSM SHALL then return to IDLE.
REQ-021 Latency: with BANKS=7, output_ready SHALL be high in the cycle following the 8th rising edge after the edge that sampled beat_tick.
REQ-022 beat_tick outside IDLE SHALL set a one-deep pending flag, serviced on the next IDLE cycle; further ticks while pending is set SHALL be dropped.
REQ-023 A change of loop_length to a value <= the current step SHALL wrap step to 0 at the next DONE.
REQ-024 When all snapshot switch bits are 0, reads still occur and looper_vector SHALL become 0.
REQ-025 mem_addr SHALL be 0 in IDLE, DONE and DRAIN.

Reset
REQ-026 While reset_n=0: state=IDLE, step=0, bank=0, pending=0, accumulator=0, looper_vector=0, output_step=0, output_ready=0, mem_addr=0.
REQ-027 Reset asserted mid-SCAN SHALL abandon the scan, and no output_ready SHALL follow its release.
REQ-028 The first beat_tick after release SHALL play step 0.

Configuration
REQ-029 Macro LOOP_PLAYER_OVERRUN_FLAG_EN defined: SHALL add output overrun (1 bit), a sticky flag set when a tick is dropped per REQ-022 and cleared only by reset.
REQ-030 Macro not defined: no overrun port and no sticky flag; tick dropping is unchanged.

Verification
REQ-031 Banks 0/1 step 0 = 16'h0001/16'h0100, loop_switches=7'b0000011, one tick -> output_ready 8 clocks later, looper_vector=16'h0101, output_step=0.
REQ-032 loop_length=3, 4 ticks spaced 20 clocks -> output_step sequence 0,1,2,0.
REQ-033 loop_switches=7'b0000010 with bank0 step0=16'hFFFF, bank1=16'h0002 -> looper_vector=16'h0002.
REQ-034 Ticks at clocks 0, 3 and 5 -> exactly two output_ready pulses (steps 0, 1); with the macro defined, overrun=1 after clock 5.
REQ-035 reset_n pulled low at clock 4 of a scan -> no output_ready; all outputs 0; the next tick yields output_step=0.
REQ-036 loop_length=0, 256 ticks -> output_step runs 0..255, and the 257th tick yields 0.
